reg_write_arbiter: RTL

//   Shares the write port of a bank of NREG 8-bit enable-gated registers among NREQ requesters.

---
 rtl/reg_write_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port among NREQ requesters.
// Define REGARB_LOCK_EN to add a per-requester lock input that parks the pointer on the winner.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 2,
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
`ifdef REGARB_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    ack,
    output logic [NREG-1:0]    reg_en,
    output logic [DW-1:0]      reg_wdata,
    output logic               addr_err,
    output logic               busy
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREG-1:0] reg_en_q, reg_en_d;
    logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
    logic            addr_err_q, addr_err_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] eff;
    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     scan;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // The requester acked this cycle is masked so a held req is not issued twice.
    assign eff  = req & ~ack_q;
    assign busy = |eff;

    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan     = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, ptr_q} + (PW+1)'(i);
            if (scan >= (PW+1)'(NREQ)) begin
                scan = scan - (PW+1)'(NREQ);
            end
            if (!found && eff[scan[PW-1:0]]) begin
                found = 1'b1;
                win   = scan[PW-1:0];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_addr = wr_addr[i*AW +: AW];
                win_data = wr_data[i*DW +: DW];
            end
        end
    end

    // NOTE: every signal gets a default before the if, so no latch is inferred.
    always_comb begin
        ack_d       = '0;
        reg_en_d    = '0;
        addr_err_d  = 1'b0;
        reg_wdata_d = reg_wdata_q;
        ptr_d       = ptr_q;
        if (found) begin
            ack_d[win]  = 1'b1;
            reg_wdata_d = win_data;
            for (int k = 0; k < NREG; k++) begin
                reg_en_d[k] = (win_addr == AW'(k));
            end
            addr_err_d = (int'(win_addr) >= NREG);
            ptr_d      = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
`ifdef REGARB_LOCK_EN
            if (lock[win]) begin
                ptr_d = win;
            end
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q       <= '0;
            reg_en_q    <= '0;
            reg_wdata_q <= '0;
            addr_err_q  <= 1'b0;
            ptr_q       <= '0;
        end else begin
            ack_q       <= ack_d;
            reg_en_q    <= reg_en_d;
            reg_wdata_q <= reg_wdata_d;
            addr_err_q  <= addr_err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign ack       = ack_q;
    assign reg_en    = reg_en_q;
    assign reg_wdata = reg_wdata_q;
    assign addr_err  = addr_err_q;
endmodule
